button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//   Consumes the 1-cycle press/release pulses of one debounced push-button and classifies each gesture
//   as SINGLE click, DOUBLE click or LONG press. Holds the result in a 1-entry event register with a
//   valid/ack handshake and a level irq, for reading by the wb_basicIO Wishbone slave.
// PARAMETERS
//   LONG_CYCLES    50_000_000  press length (clk cycles) that classifies a LONG press; >= 2
//   DCLICK_CYCLES  12_500_000  max release gap (clk cycles) before a 2nd press still counts as DOUBLE; >= 2
//   CNT_W          26          timer width; must hold max(LONG_CYCLES, DCLICK_CYCLES)
// PORTS
//   clk         in   1      system clock, all logic on posedge
//   rst_n       in   1      asynchronous reset, active low
//   pb_down     in   1      1-cycle pulse: button became pressed (debouncer output)
//   pb_up       in   1      1-cycle pulse: button became released (debouncer output)
//   ev_ack      in   1      consumer ack; clears ev_valid and ev_overrun
//   ev_valid    out  1      event register holds an unread event
//   ev_code     out  2      00 none, 01 SINGLE, 10 DOUBLE, 11 LONG; valid while ev_valid=1
//   ev_overrun  out  1      sticky: an event was dropped because ev_valid was already 1
//   irq         out  1      = ev_valid (level)
//   busy        out  1      1 while FSM not in IDLE
// BEHAVIOUR
//   Reset: FSM=IDLE, timer=0, ev_valid=0, ev_code=00, ev_overrun=0, irq=0, busy=0. Async assert, sync release.
//   pb_down and pb_up high in the same cycle: both ignored. Pulses not listed for a state: ignored.
//   Timer: cleared on each state entry, +1 per cycle in PRESS1/WAIT2, saturates at all-ones.
//   FSM states and transitions:
//     IDLE   : pb_down -> PRESS1.
//     PRESS1 : pb_up -> WAIT2.
//              timer==LONG_CYCLES-1 -> emit LONG, go HOLD.
//              The LONG event registers exactly LONG_CYCLES cycles after the pb_down cycle.
//              pb_up on that same cycle wins (-> WAIT2, no LONG).
//     WAIT2  : pb_down -> PRESS2.
//              timer==DCLICK_CYCLES-1 -> emit SINGLE, go IDLE.
//              SINGLE registers DCLICK_CYCLES cycles after the pb_up cycle.
//              pb_down on that same cycle wins (-> PRESS2).
//     PRESS2 : pb_up -> emit DOUBLE, go IDLE. No long timeout here; hold length is irrelevant.
//     HOLD   : pb_up -> IDLE, no event. Button still down after LONG.
//   Emit (next edge): if ev_valid=0 or ev_ack=1 in that cycle, then ev_code<=new and ev_valid<=1.
//     Otherwise the new event is dropped, ev_code is kept and ev_overrun<=1.
//   ev_ack: clears ev_valid and ev_overrun on the next edge unless an emit loads the same edge.
//     Emit+ack in the same cycle: ev_valid stays 1 with the new code, ev_overrun<=0.
//     ev_ack while ev_valid=0: no effect.
//   ev_code returns to 00 when ev_valid clears.
//   Handshake output is registered: ev_valid rises 1 cycle after the emitting condition.
//   rst_n low mid-gesture: gesture discarded. The next gesture needs a fresh pb_down.
//     A button held through reset is ignored until released and pressed again.
// TESTING  (LONG_CYCLES=20, DCLICK_CYCLES=10)
//   single  : pb_down@t0, pb_up@t5, nothing after -> ev_valid=1, ev_code=01 at t15, busy=0 at t15.
//   double  : down@t0, up@t3, down@t8, up@t12 -> ev_code=10, ev_valid=1 at t13; no SINGLE emitted.
//   long    : down@t0, held, up@t40 -> ev_code=11 at t20; no event at or after t40; busy=0 at t41.
//   boundary: down@t0, up@t20 -> up wins, no LONG; SINGLE at t30.
//             Also down@t0, up@t2, down@t12 -> down wins, PRESS2.
//   overrun : two SINGLE gestures with no ack -> first code kept, ev_overrun=1.
//             ev_ack -> ev_valid=0, ev_overrun=0.
//             Emit+ack same cycle -> ev_valid stays 1, new code, overrun 0.
//   reset   : rst_n low during WAIT2 -> all outputs 0 immediately.
//             pb_up then pb_down after release -> new gesture classified normally.

Source files
------------

// File: rtl/button_event_decoder.sv
// Classifies debounced push-button gestures (SINGLE / DOUBLE / LONG) and holds the
// result in a one-entry event register with valid/ack handshake and level irq.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_down,
  input  logic       pb_up,
  input  logic       ev_ack,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic       ev_overrun,
  output logic       irq,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_HOLD
  } state_t;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_SINGLE = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;
  localparam logic [1:0] CODE_LONG   = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ev_valid_q, ev_valid_d;
  logic [1:0]       ev_code_q, ev_code_d;
  logic             ev_overrun_q, ev_overrun_d;

  logic       down, up;
  logic       emit;
  logic [1:0] emit_code;

  // Simultaneous press and release pulses carry no usable ordering, so both are dropped.
  assign down = pb_down & ~pb_up;
  assign up   = pb_up & ~pb_down;

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = CODE_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (down) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (up) begin
          state_d = S_WAIT2;
        end else if (timer_q == LONG_LAST) begin
          state_d   = S_HOLD;
          emit      = 1'b1;
          emit_code = CODE_LONG;
        end
      end
      S_WAIT2: begin
        if (down) begin
          state_d = S_PRESS2;
        end else if (timer_q == DCLICK_LAST) begin
          state_d   = S_IDLE;
          emit      = 1'b1;
          emit_code = CODE_SINGLE;
        end
      end
      S_PRESS2: begin
        if (up) begin
          state_d   = S_IDLE;
          emit      = 1'b1;
          emit_code = CODE_DOUBLE;
        end
      end
      S_HOLD: begin
        if (up) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer restarts on every state change; it only runs while a timeout is armed.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == S_PRESS1 || state_q == S_WAIT2) && timer_q != CNT_MAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    ev_valid_d   = ev_valid_q;
    ev_code_d    = ev_code_q;
    ev_overrun_d = ev_overrun_q;
    if (emit) begin
      if (!ev_valid_q || ev_ack) begin
        ev_valid_d   = 1'b1;
        ev_code_d    = emit_code;
        ev_overrun_d = 1'b0;
      end else begin
        ev_overrun_d = 1'b1;
      end
    end else if (ev_ack && ev_valid_q) begin
      ev_valid_d   = 1'b0;
      ev_code_d    = CODE_NONE;
      ev_overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= CODE_NONE;
      ev_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_overrun_q <= ev_overrun_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_code    = ev_code_q;
  assign ev_overrun = ev_overrun_q;
  assign irq        = ev_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: timestamp-based gesture model, per-cycle compare,
// directed gesture scenarios with literal expectations, then random pulse traffic.
module tb_button_event_decoder;
  localparam int LONG   = 20;
  localparam int DCLICK = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb_down = 1'b0, pb_up = 1'b0, ev_ack = 1'b0;
  logic       ev_valid, ev_overrun, irq, busy;
  logic [1:0] ev_code;

  int checks = 0;
  int errors = 0;

  button_event_decoder #(.LONG_CYCLES(LONG), .DCLICK_CYCLES(DCLICK), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up), .ev_ack(ev_ack),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_overrun(ev_overrun), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Gesture model: elapsed time since the last press/release decides the outcome.
  int       cyc = 0;
  bit       m_active, m_held, m_two, m_long;
  int       m_tdown, m_tup;
  bit       m_valid, m_ovr;
  bit [1:0] m_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_held <= 0; m_two <= 0; m_long <= 0;
      m_valid <= 0; m_ovr <= 0; m_code <= 0;
    end else begin : model
      bit dn, upp, emit, a, h, two, lg, v, o;
      bit [1:0] code, c;
      int td, tu;
      dn = pb_down && !pb_up; upp = pb_up && !pb_down;
      a = m_active; h = m_held; two = m_two; lg = m_long; td = m_tdown; tu = m_tup;
      v = m_valid; o = m_ovr; c = m_code; emit = 0; code = 0;
      if (!a) begin
        if (dn) begin a = 1; h = 1; two = 0; lg = 0; td = cyc; end
      end else if (lg) begin
        if (upp) a = 0;
      end else if (h && !two) begin
        if (upp) begin h = 0; tu = cyc; end
        else if (cyc - td == LONG) begin lg = 1; emit = 1; code = 3; end
      end else if (!h) begin
        if (dn) begin h = 1; two = 1; end
        else if (cyc - tu == DCLICK) begin emit = 1; code = 1; a = 0; end
      end else begin
        if (upp) begin emit = 1; code = 2; a = 0; end
      end
      if (emit) begin
        if (!v || ev_ack) begin v = 1; c = code; o = 0; end
        else o = 1;
      end else if (ev_ack) begin
        v = 0; c = 0; o = 0;
      end
      m_active <= a; m_held <= h; m_two <= two; m_long <= lg; m_tdown <= td; m_tup <= tu;
      m_valid <= v; m_ovr <= o; m_code <= c;
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    check("cmp_valid", ev_valid, m_valid);
    check("cmp_code", ev_code, m_code);
    check("cmp_overrun", ev_overrun, m_ovr);
    check("cmp_irq", irq, m_valid);
    check("cmp_busy", busy, m_active);
  end

  // Inputs set here are sampled at the next rising edge, then cleared.
  task automatic drive(input bit d, input bit u, input bit a);
    pb_down = d; pb_up = u; ev_ack = a;
    @(posedge clk); #1;
    pb_down = 0; pb_up = 0; ev_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dbl_click();
    drive(1, 0, 0); idle(1); drive(0, 1, 0); idle(1); drive(1, 0, 0); idle(1); drive(0, 1, 0);
  endtask

  initial begin
    idle(3);
    check("rst_valid", ev_valid, 0); check("rst_code", ev_code, 0);
    check("rst_overrun", ev_overrun, 0); check("rst_irq", irq, 0); check("rst_busy", busy, 0);
    rst_n = 1; idle(2);

    // single
    drive(1, 0, 0); idle(4); drive(0, 1, 0); idle(9);
    check("single_early_valid", ev_valid, 0); check("single_early_busy", busy, 1);
    idle(1);
    check("single_valid", ev_valid, 1); check("single_code", ev_code, 1);
    check("single_busy", busy, 0); check("single_irq", irq, 1);
    drive(0, 0, 1);
    check("ack_valid", ev_valid, 0); check("ack_code", ev_code, 0);

    // double
    drive(1, 0, 0); idle(2); drive(0, 1, 0); idle(4); drive(1, 0, 0); idle(3); drive(0, 1, 0);
    check("double_code", ev_code, 2); check("double_busy", busy, 0);
    idle(1); check("double_t13_valid", ev_valid, 1);
    idle(15);
    check("double_hold_code", ev_code, 2); check("double_no_single", ev_overrun, 0);
    drive(0, 0, 1);

    // long
    drive(1, 0, 0); idle(19);
    check("long_early_valid", ev_valid, 0);
    idle(1);
    check("long_code", ev_code, 3); check("long_busy", busy, 1);
    idle(19); drive(0, 1, 0);
    check("long_release_busy", busy, 0);
    idle(1);
    check("long_t41_busy", busy, 0); check("long_no_event", ev_overrun, 0);
    check("long_kept_code", ev_code, 3);
    drive(0, 0, 1);

    // boundary: release on the LONG edge
    drive(1, 0, 0); idle(19); drive(0, 1, 0);
    check("bnd_up_valid", ev_valid, 0); check("bnd_up_busy", busy, 1);
    idle(9); check("bnd_up_early", ev_valid, 0);
    idle(1); check("bnd_up_single", ev_code, 1);
    drive(0, 0, 1);

    // boundary: second press on the SINGLE edge
    drive(1, 0, 0); idle(1); drive(0, 1, 0); idle(9); drive(1, 0, 0);
    check("bnd_dn_valid", ev_valid, 0); check("bnd_dn_busy", busy, 1);
    idle(2); drive(0, 1, 0);
    check("bnd_dn_double", ev_code, 2);
    drive(0, 0, 1);

    // overrun, ack, emit+ack
    dbl_click();
    drive(1, 0, 0); idle(1); drive(0, 1, 0); idle(10);
    check("ovr_code_kept", ev_code, 2); check("ovr_flag", ev_overrun, 1);
    check("ovr_valid", ev_valid, 1);
    drive(0, 0, 1);
    check("ovr_ack_valid", ev_valid, 0); check("ovr_ack_flag", ev_overrun, 0);
    dbl_click();
    drive(1, 0, 0); idle(1); drive(0, 1, 0); idle(9); drive(0, 0, 1);
    check("emitack_valid", ev_valid, 1); check("emitack_code", ev_code, 1);
    check("emitack_ovr", ev_overrun, 0);
    drive(0, 0, 1);

    // reset during WAIT2
    drive(1, 0, 0); idle(1); drive(0, 1, 0); idle(2);
    rst_n = 0; #1;
    check("mid_rst_busy", busy, 0); check("mid_rst_valid", ev_valid, 0);
    check("mid_rst_code", ev_code, 0); check("mid_rst_irq", irq, 0);
    idle(2); rst_n = 1; idle(2);
    drive(0, 1, 0); check("post_rst_up_ignored", busy, 0);
    idle(1); drive(1, 0, 0); check("post_rst_busy", busy, 1);
    idle(1); drive(0, 1, 0); idle(10);
    check("post_rst_single", ev_code, 1);
    drive(0, 0, 1);

    // random traffic, three pulse densities
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        pb_down = ($urandom_range(0, 6 + 6 * ph) == 0);
        pb_up   = ($urandom_range(0, 6 + 6 * ph) == 0);
        ev_ack  = ($urandom_range(0, 15) == 0);
        @(posedge clk); #1;
      end
    end
    pb_down = 0; pb_up = 0; ev_ack = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
